// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fixed-point sample FIFO family.
package fifo_pkg;

  localparam int IL_DEF = 4;
  localparam int FL_DEF = 16;

  typedef logic [IL_DEF+FL_DEF-1:0] fx_word_t;

  // Wrap with an explicit compare so that non-power-of-2 depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_mem #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [PTR_W-1:0]  ra,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Same-address read and write (full FIFO) returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd_q <= mem[ra];
  end

endmodule

// File: rtl/fifo_sync_thr.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors and flush.
module fifo_sync_thr
  import fifo_pkg::*;
#(
  parameter int IL        = IL_DEF,
  parameter int FL        = FL_DEF,
  parameter int DATA_W    = IL + FL,
  parameter int DEPTH     = 32,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr_err,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_thr: DEPTH must be >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_thr: AF_THRESH must be <= DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("fifo_sync_thr: AE_THRESH must be < DEPTH");
  end

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  next_count;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] mem_q;
  logic              dout_loaded;

  always_comb begin
    rd_ok      = ~flush & rd_en & ~empty;
    wr_ok      = ~flush & wr_en & (~full | rd_ok);
    next_count = count;
    if (flush)               next_count = '0;
    else if (wr_ok & ~rd_ok) next_count = count + 1'b1;
    else if (rd_ok & ~wr_ok) next_count = count - 1'b1;
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .wa   (wr_ptr),
    .wd   (data_in),
    .re   (rd_ok),
    .ra   (rd_ptr),
    .rd_q (mem_q)
  );

  // The RAM read register has no reset, so data_out reads as zero until the first read lands.
  assign data_out = dout_loaded ? mem_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_THRESH == 0);
      rd_valid     <= 1'b0;
      dout_loaded  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= next_count;
      empty        <= (next_count == '0);
      full         <= (next_count == CNT_W'(DEPTH));
      almost_empty <= (next_count <= CNT_W'(AE_THRESH));
      almost_full  <= (next_count >= CNT_W'(AF_THRESH));
      overflow     <= (~flush & wr_en & ~wr_ok) | (overflow & ~clr_err);
      underflow    <= (~flush & rd_en & empty) | (underflow & ~clr_err);
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (rd_ok) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
        if (wr_ok) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
        rd_valid <= rd_ok;
        if (rd_ok) dout_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Directed self-checking bench for fifo_sync_thr at DEPTH 32 and DEPTH 5.
module tb_fifo_sync_thr;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DEPTH = 32 instance
  logic       flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  fx_word_t   data_in = '0, data_out;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [5:0] count;

  // DEPTH = 5 instance
  logic       d5_flush = 1'b0, d5_clr_err = 1'b0, d5_wr_en = 1'b0, d5_rd_en = 1'b0;
  fx_word_t   d5_data_in = '0, d5_data_out;
  logic       d5_rd_valid, d5_empty, d5_full, d5_almost_empty, d5_almost_full, d5_overflow, d5_underflow;
  logic [2:0] d5_count;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  fifo_sync_thr u_dut (
    .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_thr #(.DEPTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .flush(d5_flush), .clr_err(d5_clr_err),
    .wr_en(d5_wr_en), .data_in(d5_data_in), .rd_en(d5_rd_en),
    .data_out(d5_data_out), .rd_valid(d5_rd_valid), .count(d5_count),
    .empty(d5_empty), .full(d5_full), .almost_empty(d5_almost_empty), .almost_full(d5_almost_full),
    .overflow(d5_overflow), .underflow(d5_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned wcnt, rcnt, mcnt, cyc;
    logic do_wr, do_rd;

    // Reset state
    tick(); tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    reset = 1'b0;
    tick();

    // Fill 32 words
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1; data_in = 20'(i);
      tick();
      check("fill_count", 32'(count), 32'(i));
      check("fill_af", 32'(almost_full), 32'(i >= 30));
      check("fill_ae", 32'(almost_empty), 32'(i <= 2));
      check("fill_full", 32'(full), 32'(i == 32));
    end
    data_in = 20'h21;
    tick();
    wr_en = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd32);
    check("ovf_full", 32'(full), 32'd1);
    clear_errors();
    check("ovf_clr", 32'(overflow), 32'd0);

    // Drain 32 words
    for (int i = 1; i <= 32; i++) begin
      rd_en = 1'b1;
      tick();
      check("rd_data", 32'(data_out), 32'(i));
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_count", 32'(count), 32'(32 - i));
    end
    check("rd_empty", 32'(empty), 32'd1);
    tick();
    rd_en = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_dout_hold", 32'(data_out), 32'h20);
    check("udf_rdv", 32'(rd_valid), 32'd0);
    clear_errors();
    check("udf_clr", 32'(underflow), 32'd0);

    // Full FIFO, simultaneous read and write
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1; data_in = 20'(32'h100 + i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 20'(32'hA0000 + i);
      tick();
      check("rw_full_data", 32'(data_out), 32'h101 + 32'(i));
      check("rw_full_count", 32'(count), 32'd32);
      check("rw_full_full", 32'(full), 32'd1);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rd_en = 1'b1;
      tick();
      check("rw_drain", 32'(data_out), (k < 22) ? 32'h10B + 32'(k) : 32'hA0000 + 32'(k - 22));
    end
    rd_en = 1'b0;
    check("rw_no_ovf", 32'(overflow), 32'd0);

    // Empty FIFO, simultaneous read and write: no fall-through
    wr_en = 1'b1; rd_en = 1'b1; data_in = 20'h12345;
    tick();
    wr_en = 1'b0;
    check("rw_empty_count", 32'(count), 32'd1);
    check("rw_empty_udf", 32'(underflow), 32'd1);
    check("rw_empty_rdv", 32'(rd_valid), 32'd0);
    tick();
    rd_en = 1'b0;
    check("rw_empty_data", 32'(data_out), 32'h12345);
    check("rw_empty_rdv2", 32'(rd_valid), 32'd1);
    clear_errors();

    // Flush with concurrent write
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; data_in = 20'(32'h200 + i);
      tick();
    end
    check("pre_flush_count", 32'(count), 32'd7);
    flush = 1'b1; wr_en = 1'b1; data_in = 20'h777;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_dout_hold", 32'(data_out), 32'h12345);
    wr_en = 1'b1; data_in = 20'h555;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_flush_data", 32'(data_out), 32'h555);

    // Asynchronous reset mid-cycle with rd_valid high
    wr_en = 1'b1; data_in = 20'h0AAAA;
    tick(); tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pre_rst_rdv", 32'(rd_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rdv", 32'(rd_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_ae", 32'(almost_empty), 32'd1);
    check("arst_dout", 32'(data_out), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // DEPTH = 5: interleaved traffic across pointer wraps
    wcnt = 0; rcnt = 0; mcnt = 0; cyc = 0;
    while ((wcnt < 23 || rcnt < 21) && cyc < 300) begin
      do_rd = (rcnt < 21) && (mcnt > 0) && (cyc % 3 != 0);
      do_wr = (wcnt < 23) && (cyc % 4 != 3) && (mcnt < 5 || do_rd);
      d5_rd_en = do_rd; d5_wr_en = do_wr; d5_data_in = 20'(32'h300 + wcnt);
      tick();
      if (do_rd) begin
        check("d5_data", 32'(d5_data_out), 32'h300 + rcnt);
        rcnt++;
      end
      if (do_wr) wcnt++;
      if (do_wr && !do_rd) mcnt++;
      if (do_rd && !do_wr) mcnt--;
      cyc++;
    end
    d5_rd_en = 1'b0; d5_wr_en = 1'b0;
    check("d5_done", 32'(cyc < 300), 32'd1);
    check("d5_count", 32'(d5_count), 32'd2);
    check("d5_ovf", 32'(d5_overflow), 32'd0);
    check("d5_udf", 32'(d5_underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
